clint_bus_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single CLINT memory-mapped port among NUM_REQ

---
 rtl/clint_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_clint_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter sharing the single CLINT port among NUM_REQ requesters.
// One beat per grant; a watchdog converts a stalled slave into an error response.
module clint_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    m_req_valid,
    input  logic [16*NUM_REQ-1:0] m_req_addr,
    input  logic [64*NUM_REQ-1:0] m_req_wdata,
    input  logic [NUM_REQ-1:0]    m_req_we,
    input  logic [3*NUM_REQ-1:0]  m_req_size,
    output logic [NUM_REQ-1:0]    m_req_ready,
    output logic [NUM_REQ-1:0]    m_rsp_valid,
    output logic [63:0]           m_rsp_rdata,
    output logic                  m_rsp_err,
    output logic                  s_req_valid,
    output logic [15:0]           s_req_addr,
    output logic [63:0]           s_req_wdata,
    output logic                  s_req_we,
    output logic [2:0]            s_req_size,
    input  logic                  s_req_ready,
    input  logic [63:0]           s_rdata,
    output logic                  busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        win_q, win_d;
    logic [15:0]          addr_q, addr_d;
    logic [63:0]          wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic [2:0]           size_q, size_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [63:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]   grant_c;
    logic [IW-1:0]        win_c;
    logic                 any_c;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan starts one past the last winner so every requester gets its turn.
    always_comb begin
        int idx;
        idx   = 0;
        win_c = '0;
        any_c = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!any_c && m_req_valid[idx]) begin
                any_c = 1'b1;
                win_c = IW'(idx);
            end
        end
    end

    always_comb begin
        int wi;
        wi          = int'(win_c);
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        grant_c     = '0;
        unique case (state_q)
            IDLE: begin
                if (any_c) begin
                    grant_c  = onehot(win_c);
                    win_d    = win_c;
                    rr_ptr_d = win_c;
                    addr_d   = m_req_addr[16*wi +: 16];
                    wdata_d  = m_req_wdata[64*wi +: 64];
                    we_d     = m_req_we[wi];
                    size_d   = m_req_size[3*wi +: 3];
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (s_req_ready) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_d       = '0;
                    rsp_valid_d = onehot(win_q);
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid_d = onehot(win_q);
                rsp_err_d   = 1'b0;
                rsp_rdata_d = we_q ? 64'd0 : s_rdata;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            win_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Grant is combinational, so hold it off while reset is asserted.
    assign m_req_ready = grant_c & {NUM_REQ{~reset}};
    assign m_rsp_valid = rsp_valid_q;
    assign m_rsp_rdata = rsp_rdata_q;
    assign m_rsp_err   = rsp_err_q;
    assign s_req_valid = (state_q == ISSUE);
    assign s_req_addr  = s_req_valid ? addr_q  : 16'd0;
    assign s_req_wdata = s_req_valid ? wdata_q : 64'd0;
    assign s_req_we    = s_req_valid ? we_q    : 1'b0;
    assign s_req_size  = s_req_valid ? size_q  : 3'd0;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Bench for clint_bus_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level timing model.
module tb_clint_bus_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    m_req_valid;
    logic [16*N-1:0] m_req_addr;
    logic [64*N-1:0] m_req_wdata;
    logic [N-1:0]    m_req_we;
    logic [3*N-1:0]  m_req_size;
    logic [N-1:0]    m_req_ready;
    logic [N-1:0]    m_rsp_valid;
    logic [63:0]     m_rsp_rdata;
    logic            m_rsp_err;
    logic            s_req_valid;
    logic [15:0]     s_req_addr;
    logic [63:0]     s_req_wdata;
    logic            s_req_we;
    logic [2:0]      s_req_size;
    logic            s_req_ready;
    logic [63:0]     s_rdata;
    logic            busy;

    always #5 clk = ~clk;

    clint_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .m_req_valid(m_req_valid), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_we(m_req_we),
        .m_req_size(m_req_size), .m_req_ready(m_req_ready),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err(m_rsp_err), .s_req_valid(s_req_valid),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
        .s_req_we(s_req_we), .s_req_size(s_req_size),
        .s_req_ready(s_req_ready), .s_rdata(s_rdata), .busy(busy)
    );

    // Requester-side stimulus
    logic        rv  [N];
    logic [15:0] ra  [N];
    logic [63:0] rw  [N];
    logic        rwe [N];
    logic [2:0]  rsz [N];

    always_comb begin
        m_req_valid = '0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_req_we    = '0;
        m_req_size  = '0;
        for (int i = 0; i < N; i++) begin
            m_req_valid[i]        = rv[i];
            m_req_addr[16*i +: 16] = ra[i];
            m_req_wdata[64*i +: 64] = rw[i];
            m_req_we[i]           = rwe[i];
            m_req_size[3*i +: 3]  = rsz[i];
        end
    end

    // Slave: memory that accepts after cur_stall wait cycles; rdata is junk
    // except in the cycle right after acceptance.
    bit [63:0] smem [0:65535];
    int        vcnt;
    int        cur_stall;

    assign s_req_ready = s_req_valid && (vcnt >= cur_stall);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            vcnt    <= 0;
            s_rdata <= '0;
        end else begin
            s_rdata <= {$urandom, $urandom};
            if (s_req_valid && s_req_ready) begin
                vcnt <= 0;
                if (s_req_we) begin
                    smem[s_req_addr] <= s_req_wdata;
                    s_rdata <= 64'hDEAD_BEEF_0BAD_F00D;
                end else begin
                    s_rdata <= smem[s_req_addr];
                end
            end else if (s_req_valid) begin
                vcnt <= vcnt + 1;
            end else begin
                vcnt <= 0;
            end
        end
    end

    // Reference model state
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          mode = 0;
    int          next_stall = 0;
    bit [63:0]   mmem [0:65535];
    bit          txn_active;
    int          gnt_t, rsp_at, issue_len, win_m, rr, gnt_w;
    logic [15:0] m_addr;
    logic [63:0] m_wdata;
    logic        m_we;
    logic [2:0]  m_size;
    logic [63:0] pend_rdata, hold_rdata;
    logic        pend_err, hold_err;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    function automatic bit any_rv();
        bit a;
        a = 1'b0;
        for (int i = 0; i < N; i++) a |= rv[i];
        return a;
    endfunction

    task automatic model_reset();
        txn_active = 1'b0;
        rr         = N - 1;
        hold_rdata = '0;
        hold_err   = 1'b0;
        gnt_w      = -1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] a,
                           input logic [63:0] d, input logic we, input logic [2:0] sz);
        rv[i] = v; ra[i] = a; rw[i] = d; rwe[i] = we; rsz[i] = sz;
    endtask

    task automatic new_req(input int i);
        set_req(i, 1'b1, 16'h4000 + 16'($urandom_range(0, 7)) * 16'd8,
                {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 3)));
    endtask

    task automatic drop_req(input int i);
        set_req(i, 1'b0, 16'($urandom), {$urandom, $urandom}, ~rwe[i], 3'($urandom));
    endtask

    task automatic grant(input int w);
        gnt_t   = cyc;
        win_m   = w;
        m_addr  = ra[w];
        m_wdata = rw[w];
        m_we    = rwe[w];
        m_size  = rsz[w];
        if (next_stall >= 0) cur_stall = next_stall;
        else cur_stall = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
        if (cur_stall < TO) begin
            issue_len = cur_stall + 1;
            rsp_at    = cyc + 3 + cur_stall;
            pend_err  = 1'b0;
            if (m_we) begin
                pend_rdata   = '0;
                mmem[m_addr] = m_wdata;
            end else begin
                pend_rdata = mmem[m_addr];
            end
        end else begin
            issue_len  = TO;
            rsp_at     = cyc + 1 + TO;
            pend_err   = 1'b1;
            pend_rdata = '0;
        end
        rr         = w;
        txn_active = 1'b1;
        gnt_w      = w;
    endtask

    task automatic check_cycle();
        logic [N-1:0] e_rdy, e_rsp;
        logic         e_busy, e_sv;
        logic [15:0]  e_addr;
        logic [63:0]  e_wdata;
        logic         e_we;
        logic [2:0]   e_size;
        int           w;
        e_rdy = '0; e_rsp = '0; e_busy = 1'b0; e_sv = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            if (txn_active && cyc == rsp_at) begin
                e_rsp[win_m] = 1'b1;
                hold_rdata   = pend_rdata;
                hold_err     = pend_err;
                txn_active   = 1'b0;
            end
            if (txn_active && cyc > gnt_t) begin
                e_busy = 1'b1;
                e_sv   = (cyc <= gnt_t + issue_len);
            end
        end
        e_addr  = e_sv ? m_addr  : 16'd0;
        e_wdata = e_sv ? m_wdata : 64'd0;
        e_we    = e_sv ? m_we    : 1'b0;
        e_size  = e_sv ? m_size  : 3'd0;
        if (!reset && !txn_active) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && rv[(rr + k) % N]) w = (rr + k) % N;
            if (w >= 0) begin
                e_rdy[w] = 1'b1;
                grant(w);
            end
        end
        chk("m_req_ready", 64'(m_req_ready), 64'(e_rdy));
        chk("m_rsp_valid", 64'(m_rsp_valid), 64'(e_rsp));
        chk("m_rsp_rdata", m_rsp_rdata, hold_rdata);
        chk("m_rsp_err",   64'(m_rsp_err),   64'(hold_err));
        chk("busy",        64'(busy),        64'(e_busy));
        chk("s_req_valid", 64'(s_req_valid), 64'(e_sv));
        chk("s_req_addr",  64'(s_req_addr),  64'(e_addr));
        chk("s_req_wdata", s_req_wdata,      e_wdata);
        chk("s_req_we",    64'(s_req_we),    64'(e_we));
        chk("s_req_size",  64'(s_req_size),  64'(e_size));
    endtask

    // Requesters react to the grant just after the following clock edge.
    task automatic apply_updates();
        if (gnt_w >= 0) begin
            if (mode == 0) drop_req(gnt_w);
            else if (mode == 2) begin
                if ($urandom_range(0, 1) == 1) new_req(gnt_w);
                else drop_req(gnt_w);
            end
        end
        if (mode == 2)
            for (int i = 0; i < N; i++)
                if (i != gnt_w && !rv[i] && $urandom_range(0, 2) == 0) new_req(i);
        gnt_w = -1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_cycle();
        @(posedge clk);
        #1;
        apply_updates();
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (!txn_active && gnt_w < 0 && !any_rv()) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) done = !txn_active && gnt_w < 0 && !any_rv();
        vectors++;
        assert (done) else begin
            miscompares++;
            $error("FAIL drain: observed still busy, expected idle within %0d cycles", budget);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, 1'b0, '0);
        cur_stall = 0;
        model_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Preset then read back the timer register
        set_req(0, 1'b1, 16'hBFF8, 64'h100, 1'b1, 3'd3);
        drain(20);
        set_req(0, 1'b1, 16'hBFF8, 64'h0, 1'b0, 3'd3);
        drain(20);

        // Contention from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        step();
        reset = 1'b0;
        mode = 1;
        set_req(0, 1'b1, 16'h4000, 64'h0, 1'b0, 3'd3);
        set_req(1, 1'b1, 16'h4008, 64'h0, 1'b0, 3'd2);
        repeat (13) step();
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        mode = 0;
        drain(20);

        // Write then read back through requester 1
        set_req(1, 1'b1, 16'h4000, 64'h1234, 1'b1, 3'd3);
        drain(20);
        set_req(1, 1'b1, 16'h4000, 64'h0, 1'b0, 3'd3);
        drain(20);

        // Stalled slave -> watchdog error
        next_stall = 100;
        set_req(0, 1'b1, 16'h4010, 64'h0, 1'b0, 3'd3);
        drain(40);
        set_req(2, 1'b1, 16'h4018, 64'h55, 1'b1, 3'd1);
        drain(40);
        next_stall = 0;

        // Reset in the first issue cycle abandons the transaction
        set_req(1, 1'b1, 16'h4020, 64'h0, 1'b0, 3'd3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 1'b1, 16'h4000, 64'h0, 1'b0, 3'd3);
        set_req(1, 1'b1, 16'h4008, 64'h0, 1'b0, 3'd3);
        drain(30);

        // Random traffic with random slave stalls
        mode = 2;
        next_stall = -1;
        for (int i = 0; i < N; i++) new_req(i);
        repeat (900) step();
        mode = 0;
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        drain(40);
        next_stall = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
